axis_s_rx: RTL and testbench
============================

Name: axis_s_rx

Overview:
AXI-Stream slave receiver that accepts beats from an upstream stream master, such as the team's single-beat sender. Accepted beats and their tlast flag go into a small show-ahead FIFO. The FIFO is drained by a local read port. The block also tracks packet boundaries: it pulses `pkt_done` on each accepted tlast beat and reports the length of the last completed packet plus a running packet count.

Parameters:
- DATA_W, 32, width of tdata and rd_data.
- DEPTH_LOG2, 2, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 4 entries); must be ≥ 1.
- LEN_W, 16, width of the beat counter and of `last_len`.
- PKT_W, 16, width of `pkt_cnt`.

Ports:
- aclk, input, 1, single clock; all logic on the rising edge.
- areset, input, 1, asynchronous active-high reset.
- tvalid, input, 1, upstream beat valid.
- tready, output, 1, receiver can accept a beat.
- tdata, input, DATA_W, upstream beat data.
- tlast, input, 1, upstream beat is the last of its packet.
- rd_valid, output, 1, FIFO head entry is valid (FIFO not empty).
- rd_data, output, DATA_W, FIFO head data (show-ahead).
- rd_last, output, 1, tlast flag stored with the head entry.
- rd_en, input, 1, pop the head entry; ignored when rd_valid = 0.
- level, output, DEPTH_LOG2+1, number of stored entries, 0..DEPTH.
- pkt_done, output, 1, one-cycle pulse after a tlast beat is accepted.
- last_len, output, LEN_W, beat count of the most recently completed packet.
- pkt_cnt, output, PKT_W, number of completed packets since reset; wraps.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream) forces: wr_ptr = 0, rd_ptr = 0, level = 0, beat_cnt = 0, last_len = 0, pkt_cnt = 0, pkt_done = 0.
  - Resulting outputs: tready = 1, rd_valid = 0, rd_last = 0, rd_data = don't-care. The bench checks rd_data only when rd_valid = 1.
  - FIFO memory is not reset.
- Reset mid-operation discards all stored entries and any partial packet count immediately.
- Handshake and push:
  - `accept = tvalid & tready`.
  - tready = (level != DEPTH). It is decoded from registers only, with no combinational path from tvalid.
  - On accept: mem[wr_ptr] <= {tlast, tdata}, wr_ptr increments. Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
  - tvalid without tready: nothing is stored. The master is required to hold tdata/tlast stable; the receiver does not check this.
- Pop:
  - `pop = rd_en & rd_valid`.
  - rd_valid = (level != 0).
  - rd_data/rd_last = mem[rd_ptr], combinational from registers.
  - On pop, rd_ptr increments (wraps).
- Level:
  - +1 on accept only, -1 on pop only, unchanged on both or neither.
  - Simultaneous accept and pop at any level 1..DEPTH-1 keeps level constant.
  - At level = DEPTH, accept is impossible; a pop raises tready the next cycle, giving 1-cycle bubble latency.
  - At level = 0, a pop is impossible; an accepted beat is visible on rd_valid the next cycle. FIFO latency is 1 cycle.
- Packet tracking:
  - beat_cnt counts accepted beats of the current packet.
  - On accept with tlast = 0: beat_cnt <= beat_cnt + 1, saturating at all-ones.
  - On accept with tlast = 1:
    - last_len <= beat_cnt + 1, saturating at all-ones.
    - beat_cnt <= 0.
    - pkt_cnt <= pkt_cnt + 1, modulo 2**PKT_W.
    - pkt_done <= 1 for exactly the next cycle.
  - pkt_done is 0 in every other cycle.
  - Back-to-back single-beat packets produce pkt_done high on consecutive cycles, and last_len = 1 each time.
- No other state machine: the control state is {level, pointers, beat_cnt}.

Test Plan:
1. Reset, then idle. Required: tready = 1, rd_valid = 0, level = 0, pkt_cnt = 0, pkt_done = 0. Assert areset mid-stream with level = 3: all of these return to their reset values asynchronously.
2. Single beat: tdata = 32'hDEADBEEF with tlast = 1, rd_en = 0.
   - Next cycle: rd_valid = 1, rd_data = DEADBEEF, rd_last = 1, level = 1, pkt_done = 1, last_len = 1, pkt_cnt = 1.
   - Following cycle: pkt_done = 0.
3. Fill to full: send 5 beats 1..5 with tlast = 0, rd_en = 0.
   - Required: beats 1-4 accepted, tready = 0 after the 4th, beat 5 held. level = 4.
   - One pop: rd_data = 1 popped, tready = 1 the next cycle, beat 5 accepted, level back to 4.
4. Wrap-around with concurrent traffic: stream 20 beats (values 0x100..0x113) with tvalid and rd_en continuously high.
   - Required: read order matches write order, no beat lost or duplicated, level stays ≤ 1.
   - wr_ptr and rd_ptr each wrap 5 times.
5. Packet length: send a 3-beat packet (tlast on the 3rd beat) and then a 1-beat packet.
   - Required: pkt_done pulses twice; last_len = 3 then 1; pkt_cnt goes 1, 2.
   - FIFO drain shows rd_last = 0, 0, 1, 1.
6. Simultaneous accept and pop at level = 2. Required: level stays 2 and the head advances by one entry. Then attempt rd_en at level = 0: no pointer change, level stays 0.

Source files
------------

// File: rtl/axis_s_rx.sv
// AXI-Stream slave receiver: show-ahead FIFO for {tlast, tdata} beats,
// with packet-boundary tracking (done pulse, last packet length, packet count).
module axis_s_rx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned PKT_W      = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  tvalid,
  output logic                  tready,
  input  logic [DATA_W-1:0]     tdata,
  input  logic                  tlast,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  input  logic                  rd_en,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  pkt_done,
  output logic [LEN_W-1:0]      last_len,
  output logic [PKT_W-1:0]      pkt_cnt
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W   = DEPTH_LOG2 + 1;
  localparam int unsigned ENTRY_W = DATA_W + 1;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic [LEN_W-1:0]      beat_cnt;
  logic                  accept;
  logic                  pop;

  // Flow control decoded from the level register only.
  assign tready   = (level_q != LVL_W'(DEPTH));
  assign rd_valid = (level_q != LVL_W'(0));
  assign accept   = tvalid & tready;
  assign pop      = rd_en & rd_valid;
  assign level    = level_q;

  // Head entry; rd_last is qualified so it reads 0 while the FIFO is empty.
  assign rd_data = mem[rd_ptr][DATA_W-1:0];
  assign rd_last = rd_valid & mem[rd_ptr][DATA_W];

  always_ff @(posedge aclk) begin
    if (accept) begin
      mem[wr_ptr] <= {tlast, tdata};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({accept, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Packet boundary tracking; counters saturate, packet count wraps.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt <= '0;
      last_len <= '0;
      pkt_cnt  <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (accept) begin
        if (tlast) begin
          last_len <= (beat_cnt == '1) ? beat_cnt : beat_cnt + LEN_W'(1);
          beat_cnt <= '0;
          pkt_cnt  <= pkt_cnt + PKT_W'(1);
          pkt_done <= 1'b1;
        end else if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_s_rx.sv
// Scoreboard bench for axis_s_rx: a reference queue and packet model track
// every handshake and are compared against the DUT each cycle.
module tb_axis_s_rx;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              aclk;
  logic              areset;
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_en;
  logic [2:0]        level;
  logic              pkt_done;
  logic [15:0]       last_len;
  logic [15:0]       pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t       sb_q[$];
  logic        exp_done;
  logic [15:0] exp_len;
  logic [15:0] exp_pcnt;
  logic [15:0] exp_beat;
  logic        in_stream;
  logic        m_acc;
  logic        m_pop;

  axis_s_rx dut (
    .aclk     (aclk),
    .areset   (areset),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tlast    (tlast),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_en    (rd_en),
    .level    (level),
    .pkt_done (pkt_done),
    .last_len (last_len),
    .pkt_cnt  (pkt_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model update and comparison on the falling edge, where DUT state is stable.
  always @(negedge aclk) begin
    if (areset) begin
      sb_q.delete();
      exp_done = 1'b0;
      exp_len  = '0;
      exp_pcnt = '0;
      exp_beat = '0;
    end else begin
      check("level",    64'(level),    64'(sb_q.size()));
      check("tready",   64'(tready),   64'(sb_q.size() != DEPTH));
      check("rd_valid", 64'(rd_valid), 64'(sb_q.size() != 0));
      check("pkt_done", 64'(pkt_done), 64'(exp_done));
      check("last_len", 64'(last_len), 64'(exp_len));
      check("pkt_cnt",  64'(pkt_cnt),  64'(exp_pcnt));
      if (sb_q.size() != 0) begin
        check("rd_data", 64'(rd_data), 64'(sb_q[0].data));
        check("rd_last", 64'(rd_last), 64'(sb_q[0].last));
      end
      if (in_stream) check("lvl_le1", 64'(level <= 3'd1), 64'd1);
      m_acc = tvalid && (sb_q.size() < DEPTH);
      m_pop = rd_en && (sb_q.size() != 0);
      if (m_pop) void'(sb_q.pop_front());
      if (m_acc) sb_q.push_back('{last: tlast, data: tdata});
      exp_done = 1'b0;
      if (m_acc) begin
        if (tlast) begin
          exp_len  = (exp_beat == 16'hFFFF) ? 16'hFFFF : exp_beat + 16'd1;
          exp_beat = '0;
          exp_pcnt = exp_pcnt + 16'd1;
          exp_done = 1'b1;
        end else if (exp_beat != 16'hFFFF) begin
          exp_beat = exp_beat + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present a beat and hold it until it is accepted; tvalid stays high on return.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l);
    logic acc;
    acc    = 1'b0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge aclk);
      acc = tready;
      tick();
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tvalid = 1'b0;
    rd_en  = 1'b0;
    #1;
    check("rst_tready",   64'(tready),   64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_level",    64'(level),    64'd0);
    check("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    check("rst_rd_last",  64'(rd_last),  64'd0);
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    areset    = 1'b1;
    tvalid    = 1'b0;
    tdata     = '0;
    tlast     = 1'b0;
    rd_en     = 1'b0;
    in_stream = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    tick();
    tick();

    // Idle after reset, then an asynchronous reset with three entries stored.
    check("idle_tready", 64'(tready), 64'd1);
    check("idle_level",  64'(level),  64'd0);
    send_beat(32'hA0, 1'b0);
    send_beat(32'hA1, 1'b0);
    send_beat(32'hA2, 1'b1);
    tvalid = 1'b0;
    check("pre_rst_level", 64'(level), 64'd3);
    do_reset();
    tick();

    // Single-beat packet.
    send_beat(32'hDEADBEEF, 1'b1);
    tvalid = 1'b0;
    check("sb_rd_valid", 64'(rd_valid), 64'd1);
    check("sb_rd_data",  64'(rd_data),  64'hDEADBEEF);
    check("sb_rd_last",  64'(rd_last),  64'd1);
    check("sb_level",    64'(level),    64'd1);
    check("sb_pkt_done", 64'(pkt_done), 64'd1);
    check("sb_last_len", 64'(last_len), 64'd1);
    check("sb_pkt_cnt",  64'(pkt_cnt),  64'd1);
    tick();
    check("sb_pkt_done_clr", 64'(pkt_done), 64'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;

    // Fill to full; the fifth beat is held off until a pop frees a slot.
    for (int i = 1; i <= 4; i++) send_beat(DATA_W'(i), 1'b0);
    check("full_tready", 64'(tready), 64'd0);
    check("full_level",  64'(level),  64'd4);
    tvalid = 1'b1;
    tdata  = 32'd5;
    tlast  = 1'b0;
    tick();
    tick();
    check("held_level", 64'(level), 64'd4);
    check("head_is_1",  64'(rd_data), 64'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_tready", 64'(tready), 64'd1);
    check("pop_level",  64'(level),  64'd3);
    tick();
    tvalid = 1'b0;
    check("refill_level", 64'(level), 64'd4);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_en = 1'b0;
    check("drained_level", 64'(level), 64'd0);

    // Continuous streaming with concurrent reads; pointers wrap several times.
    in_stream = 1'b1;
    rd_en     = 1'b1;
    for (int i = 0; i < 20; i++) send_beat(32'h100 + DATA_W'(i), 1'b0);
    tvalid = 1'b0;
    tick();
    in_stream = 1'b0;
    rd_en     = 1'b0;
    check("stream_level", 64'(level), 64'd0);

    // Packet lengths: a 3-beat packet then a 1-beat packet.
    do_reset();
    tick();
    send_beat(32'h31, 1'b0);
    send_beat(32'h32, 1'b0);
    send_beat(32'h33, 1'b1);
    check("p3_last_len", 64'(last_len), 64'd3);
    check("p3_pkt_cnt",  64'(pkt_cnt),  64'd1);
    send_beat(32'h41, 1'b1);
    tvalid = 1'b0;
    check("p1_last_len", 64'(last_len), 64'd1);
    check("p1_pkt_cnt",  64'(pkt_cnt),  64'd2);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_en = 1'b0;

    // Simultaneous accept and pop at level 2, then reads against an empty FIFO.
    send_beat(32'h51, 1'b0);
    send_beat(32'h52, 1'b0);
    tdata = 32'h53;
    rd_en = 1'b1;
    tick();
    tvalid = 1'b0;
    rd_en  = 1'b0;
    check("sim_level", 64'(level),   64'd2);
    check("sim_head",  64'(rd_data), 64'h52);
    rd_en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rd_en = 1'b0;
    check("empty_level",    64'(level),    64'd0);
    check("empty_rd_valid", 64'(rd_valid), 64'd0);
    send_beat(32'h61, 1'b1);
    tvalid = 1'b0;
    check("after_empty_head", 64'(rd_data), 64'h61);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
